digdug_devbus_arbiter: RTL and testbench
========================================

// Module: digdug_devbus_arbiter
// PURPOSE
// - Shares the common I/O device bus (DEV_AD/RD/WR/DI in, DEV_DV/DO back) between the three Z80 cores: 0=main, 1=sub, 2=sound.
// - Sits between DIGDUG_CORES and DIGDUG_IODEV.
// - Serialises one access at a time with round-robin fairness.
// - Returns read data and a one-cycle ACK to the winning core.
// PARAMETERS
// - NREQ     3    number of requesters (fixed at 3; packed buses below are sized for it)
// - TMO_CYC  255  read timeout in MCLK cycles (1..255); used only with DEVARB_TIMEOUT_EN
// PORTS
// - MCLK      in   1   clock (48 MHz); all logic on the rising edge
// - RESET_N   in   1   synchronous reset, active-low
// - PAUSE     in   1   1 = no new grants; the transfer in flight completes
// - REQ       in   3   per-core request; held high until that core's ACK
// - REQ_RD    in   3   per-core read strobe, qualified by REQ
// - REQ_WR    in   3   per-core write strobe, qualified by REQ
// - REQ_AD    in   48  per-core address; core k uses bits [16k+15:16k]
// - REQ_DI    in   24  per-core write data; core k uses bits [8k+7:8k]
// - ACK       out  3   one-hot, one-cycle completion pulse
// - RDATA     out  8   read data, valid in the ACK cycle
// - DEV_AD    out  16  shared bus address
// - DEV_RD    out  1   shared bus read strobe
// - DEV_WR    out  1   shared bus write strobe
// - DEV_DI    out  8   shared bus write data
// - DEV_DV    in   1   device read-data valid
// - DEV_DO    in   8   device read data
// - GRANT     out  2   index of the current or last owner (debug/LED)
// - TMO_ERR   out  1   sticky read-timeout flag
// BEHAVIOUR
// - Reset (RESET_N low at a rising edge): all outputs 0; state IDLE; round-robin pointer LAST=2, so core 0 has first priority.
// - States: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
//   - IDLE: if PAUSE=0 and any REQ is set, grant the first set REQ, searching LAST+1, LAST+2, LAST (mod 3).
//     - Latch that core's AD, DI and RD/WR into internal registers; set GRANT and LAST; go to ISSUE.
//   - ISSUE: drive DEV_AD/DEV_DI from the latched values for exactly 1 cycle.
//     - Write: DEV_WR=1 this cycle; go to DONE.
//     - Read: DEV_RD=1 this cycle; if DEV_DV=1, capture DEV_DO and go to DONE, else go to WAIT.
//   - WAIT: DEV_RD=0; DEV_AD stays stable; capture DEV_DO on the first DEV_DV=1 and go to DONE.
//   - DONE: ACK[GRANT]=1 for 1 cycle; RDATA holds the captured data (writes leave RDATA unchanged); go to IDLE.
// - Latency (REQ sampled in IDLE at cycle n):
//   - strobe at n+1;
//   - write ACK at n+2;
//   - read ACK at n+2+k, where k = cycles of WAIT.
// - Minimum issue spacing is 3 cycles. A core re-requesting right after its ACK loses to any other pending core.
// - DEV_RD and DEV_WR are never high together, and each is high for at most 1 cycle per transfer.
// - REQ_RD=REQ_WR=1 together: treated as a write.
// - REQ_RD=REQ_WR=0 with REQ=1: treated as a write that does not strobe DEV_WR (dummy cycle); ACK is still given.
// - REQ dropped after grant: the transfer completes and ACK still pulses. The core must ignore it.
// - Inputs are latched at grant; later changes to REQ_AD/REQ_DI have no effect on the current transfer.
// - DEV_DV outside ISSUE/WAIT is ignored.
// - PAUSE rising mid-transfer: the transfer completes, then IDLE holds.
// - RESET_N low mid-transfer: abort at once; no ACK; all outputs 0 on the next edge.
// CONFIGURATION
// - Macro DEVARB_TIMEOUT_EN.
//   - Defined:
//     - An 8-bit counter clears on entry to ISSUE and increments in WAIT.
//     - When it reaches TMO_CYC in WAIT: go to DONE with RDATA=8'hFF and set TMO_ERR=1.
//     - TMO_ERR stays 1 until reset.
//   - Undefined: WAIT holds indefinitely; TMO_ERR is tied to 0; no counter is synthesised.
// TESTING
// - Reset, then REQ=3'b001 write AD=16'h7000, DI=8'hA5 -> DEV_WR=1 with AD 7000 and DI A5 at n+1; ACK=3'b001 at n+2; GRANT=0.
// - REQ=3'b111, all reads, DEV_DV returned with DEV_DO = 8'h10/8'h11/8'h12 -> grant order 0,1,2,0; each ACK carries the matching RDATA; no overlap of DEV_RD.
// - Core 1 read, DEV_DV delayed 5 cycles, DEV_DO=8'h3C -> DEV_RD high for 1 cycle; ACK=3'b010 at n+7 with RDATA=8'h3C.
// - PAUSE=1 raised during a core-2 write -> that write's ACK still occurs; no new DEV_RD/WR while PAUSE=1; core 0 is granted on the first cycle after PAUSE=0.
// - RESET_N=0 in WAIT -> next edge: ACK=0, DEV_*=0, LAST=2; the next REQ=3'b011 grants core 0.
// - With DEVARB_TIMEOUT_EN and TMO_CYC=4, a read with no DEV_DV -> ACK with RDATA=8'hFF after 4 WAIT cycles; TMO_ERR=1, still 1 after a later good read.

Source files
------------

// File: rtl/digdug_devbus_arbiter.sv
// Round-robin arbiter sharing the I/O device bus between main/sub/sound Z80 cores; DEVARB_TIMEOUT_EN adds a read timeout.
// Latency: strobe 1 cycle after grant, ACK 2 cycles after grant (+1 per WAIT cycle on reads).
// Backpressure: REQ held until ACK; PAUSE blocks new grants; reads stall in WAIT until DEV_DV.
module digdug_devbus_arbiter #(
    parameter int NREQ    = 3,
    parameter int TMO_CYC = 255
) (
    input  logic                MCLK,
    input  logic                RESET_N,
    input  logic                PAUSE,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ-1:0]     REQ_RD,
    input  logic [NREQ-1:0]     REQ_WR,
    input  logic [16*NREQ-1:0]  REQ_AD,
    input  logic [8*NREQ-1:0]   REQ_DI,
    output logic [NREQ-1:0]     ACK,
    output logic [7:0]          RDATA,
    output logic [15:0]         DEV_AD,
    output logic                DEV_RD,
    output logic                DEV_WR,
    output logic [7:0]          DEV_DI,
    input  logic                DEV_DV,
    input  logic [7:0]          DEV_DO,
    output logic [1:0]          GRANT,
    output logic                TMO_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_t     state;
    logic [1:0] last;
    logic       op_rd;
    logic       pick_vld;
    logic [1:0] pick_idx;
    logic [1:0] cand_idx;

    // Search LAST+1, LAST+2, LAST; iterate backwards so the nearest candidate wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last;
        cand_idx = 2'd0;
        for (int j = NREQ; j >= 1; j--) begin
            cand_idx = 2'((int'(last) + j) % NREQ);
            if (REQ[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

`ifdef DEVARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
`else
    // Only meaningful with the timeout counter; its legal range keeps this at 0.
    assign TMO_ERR = (TMO_CYC == 0);
`endif

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state  <= S_IDLE;
            last   <= 2'd2;
            op_rd  <= 1'b0;
            ACK    <= '0;
            RDATA  <= 8'h00;
            DEV_AD <= 16'h0000;
            DEV_RD <= 1'b0;
            DEV_WR <= 1'b0;
            DEV_DI <= 8'h00;
            GRANT  <= 2'd0;
`ifdef DEVARB_TIMEOUT_EN
            tmo_cnt <= 8'd0;
            TMO_ERR <= 1'b0;
`endif
        end else begin
            DEV_RD <= 1'b0;
            DEV_WR <= 1'b0;
            ACK    <= '0;
            case (state)
                S_IDLE: begin
                    if (!PAUSE && pick_vld) begin
                        GRANT  <= pick_idx;
                        last   <= pick_idx;
                        DEV_AD <= REQ_AD[16*pick_idx +: 16];
                        DEV_DI <= REQ_DI[8*pick_idx +: 8];
                        // RD+WR together is a write; neither is a dummy write with no strobe.
                        op_rd  <= REQ_RD[pick_idx] & ~REQ_WR[pick_idx];
                        DEV_RD <= REQ_RD[pick_idx] & ~REQ_WR[pick_idx];
                        DEV_WR <= REQ_WR[pick_idx];
`ifdef DEVARB_TIMEOUT_EN
                        tmo_cnt <= 8'd0;
`endif
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!op_rd) begin
                        ACK   <= ONE_HOT0 << GRANT;
                        state <= S_DONE;
                    end else if (DEV_DV) begin
                        RDATA <= DEV_DO;
                        ACK   <= ONE_HOT0 << GRANT;
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (DEV_DV) begin
                        RDATA <= DEV_DO;
                        ACK   <= ONE_HOT0 << GRANT;
                        state <= S_DONE;
                    end
`ifdef DEVARB_TIMEOUT_EN
                    else if (tmo_cnt == 8'(TMO_CYC - 1)) begin
                        RDATA   <= 8'hFF;
                        TMO_ERR <= 1'b1;
                        ACK     <= ONE_HOT0 << GRANT;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digdug_devbus_arbiter.sv
// Scoreboard bench for digdug_devbus_arbiter: directed requests push expected bus strobes and ACKs.
module tb_digdug_devbus_arbiter;

    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        PAUSE = 1'b0;
    logic [2:0]  REQ = '0;
    logic [2:0]  REQ_RD = '0;
    logic [2:0]  REQ_WR = '0;
    logic [47:0] REQ_AD = '0;
    logic [23:0] REQ_DI = '0;
    logic [2:0]  ACK;
    logic [7:0]  RDATA;
    logic [15:0] DEV_AD;
    logic        DEV_RD;
    logic        DEV_WR;
    logic [7:0]  DEV_DI;
    logic        DEV_DV = 1'b0;
    logic [7:0]  DEV_DO = 8'h00;
    logic [1:0]  GRANT;
    logic        TMO_ERR;

    digdug_devbus_arbiter #(.NREQ(3), .TMO_CYC(4)) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .PAUSE(PAUSE),
        .REQ(REQ), .REQ_RD(REQ_RD), .REQ_WR(REQ_WR), .REQ_AD(REQ_AD), .REQ_DI(REQ_DI),
        .ACK(ACK), .RDATA(RDATA),
        .DEV_AD(DEV_AD), .DEV_RD(DEV_RD), .DEV_WR(DEV_WR), .DEV_DI(DEV_DI),
        .DEV_DV(DEV_DV), .DEV_DO(DEV_DO),
        .GRANT(GRANT), .TMO_ERR(TMO_ERR)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        int          cyc;
        logic        rd;
        logic        wr;
        logic [15:0] ad;
        logic [7:0]  di;
    } bus_t;

    typedef struct packed {
        int          cyc;
        logic [2:0]  ack;
        logic [7:0]  rdata;
    } ack_t;

    typedef struct {
        int         dly;
        logic [7:0] dat;
    } dev_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    dev_t dev_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    always @(posedge MCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Device model: answers each read after its queued delay (0 = same cycle, <0 = never).
    int         dv_cnt = -1;
    logic [7:0] dv_pend = 8'h00;
    always @(negedge MCLK) begin
        dev_t d;
        DEV_DV = 1'b0;
        if (!RESET_N) begin
            dv_cnt = -1;
        end else if (DEV_RD) begin
            d.dly = -1;
            d.dat = 8'h00;
            if (dev_q.size() != 0) d = dev_q.pop_front();
            if (d.dly == 0) begin
                DEV_DV = 1'b1;
                DEV_DO = d.dat;
                dv_cnt = -1;
            end else begin
                dv_cnt  = d.dly;
                dv_pend = d.dat;
            end
        end else if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
                DEV_DV = 1'b1;
                DEV_DO = dv_pend;
                dv_cnt = -1;
            end
        end
    end

    // Monitor: every strobe and every ACK must match the head of its queue, cycle included.
    always @(negedge MCLK) begin
        bus_t ab;
        ack_t aa;
        if (DEV_RD && DEV_WR) chk("rd_wr_overlap", {DEV_RD, DEV_WR}, 2'b00);
        if (DEV_RD || DEV_WR) begin
            ab = '{cyc: cyc, rd: DEV_RD, wr: DEV_WR, ad: DEV_AD, di: DEV_DI};
            if (bus_q.size() == 0) chk("bus_unexpected", 64'(ab), 64'(0));
            else chk("bus_cyc_rd_wr_ad_di", 64'(ab), 64'(bus_q.pop_front()));
        end
        if (ACK != 3'b000) begin
            aa = '{cyc: cyc, ack: ACK, rdata: RDATA};
            if (ack_q.size() == 0) chk("ack_unexpected", 64'(aa), 64'(0));
            else chk("ack_cyc_ack_rdata", 64'(aa), 64'(ack_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic set_core(input int k, input logic rd, input logic wr,
                            input logic [15:0] ad, input logic [7:0] di);
        REQ_RD[k]          = rd;
        REQ_WR[k]          = wr;
        REQ_AD[16*k +: 16] = ad;
        REQ_DI[8*k +: 8]   = di;
    endtask

    task automatic exp_bus(input int c, input logic rd, input logic wr,
                           input logic [15:0] ad, input logic [7:0] di);
        bus_q.push_back('{cyc: c, rd: rd, wr: wr, ad: ad, di: di});
    endtask

    task automatic exp_ack(input int c, input logic [2:0] a, input logic [7:0] d);
        ack_q.push_back('{cyc: c, ack: a, rdata: d});
    endtask

    task automatic dev_push(input int dly, input logic [7:0] dat);
        dev_q.push_back('{dly: dly, dat: dat});
    endtask

    // Core side: drop REQ on ACK; cores in `rearm` re-request once right after their ACK.
    task automatic serve(input int nack, input logic [2:0] rearm);
        int         got = 0;
        logic [2:0] rm = rearm;
        for (int i = 0; i < 300 && got < nack; i++) begin
            @(posedge MCLK);
            #1;
            if (ACK != 3'b000) begin
                REQ = (REQ & ~ACK) | (rm & ACK);
                rm  = rm & ~ACK;
                got++;
            end
        end
        chk("ack_count", 64'(got), 64'(nack));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        int c;
        RESET_N = 1'b0;
        tick(3);
        chk("reset_ack_rdata", {ACK, RDATA}, 11'h000);
        chk("reset_dev", {DEV_AD, DEV_RD, DEV_WR, DEV_DI}, 26'h0);
        chk("reset_grant_tmo", {GRANT, TMO_ERR}, 3'b000);
        RESET_N = 1'b1;
        tick(2);

        // Core 0 write straight after reset.
        c = cyc;
        set_core(0, 1'b0, 1'b1, 16'h7000, 8'hA5);
        REQ = 3'b001;
        exp_bus(c + 1, 1'b0, 1'b1, 16'h7000, 8'hA5);
        exp_ack(c + 2, 3'b001, 8'h00);
        serve(1, 3'b000);
        tick(2);
        chk("grant_after_core0", GRANT, 2'd0);

        // Core 1 read, device answers 5 cycles after the strobe; AD must not follow REQ_AD.
        c = cyc;
        set_core(1, 1'b1, 1'b0, 16'h6810, 8'h00);
        dev_push(5, 8'h3C);
        REQ = 3'b010;
        exp_bus(c + 1, 1'b1, 1'b0, 16'h6810, 8'h00);
        exp_ack(c + 7, 3'b010, 8'h3C);
        tick(3);
        REQ_AD[31:16] = 16'hFFFF;
        chk("wait_ad_stable", DEV_AD, 16'h6810);
        serve(1, 3'b000);
        tick(2);
        chk("grant_after_core1", GRANT, 2'd1);

        // Core 2 RD+WR counts as a write; core 1 with neither strobe is a silent dummy.
        c = cyc;
        set_core(2, 1'b1, 1'b1, 16'h3333, 8'h09);
        set_core(1, 1'b0, 1'b0, 16'h4444, 8'h0A);
        REQ = 3'b110;
        exp_bus(c + 1, 1'b0, 1'b1, 16'h3333, 8'h09);
        exp_ack(c + 2, 3'b100, 8'h3C);
        exp_ack(c + 5, 3'b010, 8'h3C);
        serve(2, 3'b000);
        tick(2);

        // Core 2 drops REQ right after grant; ACK still arrives.
        c = cyc;
        set_core(2, 1'b0, 1'b1, 16'h5555, 8'h0B);
        REQ = 3'b100;
        exp_bus(c + 1, 1'b0, 1'b1, 16'h5555, 8'h0B);
        exp_ack(c + 2, 3'b100, 8'h3C);
        tick(1);
        REQ = 3'b000;
        serve(1, 3'b000);
        tick(2);

        // All three read; core 0 re-requests after its ACK and goes to the back.
        c = cyc;
        for (int k = 0; k < 3; k++) set_core(k, 1'b1, 1'b0, 16'h8000 + 16'(k), 8'(8'h11 * k));
        dev_push(0, 8'h10);
        dev_push(0, 8'h11);
        dev_push(0, 8'h12);
        dev_push(0, 8'h10);
        REQ = 3'b111;
        exp_bus(c + 1,  1'b1, 1'b0, 16'h8000, 8'h00);
        exp_ack(c + 2,  3'b001, 8'h10);
        exp_bus(c + 4,  1'b1, 1'b0, 16'h8001, 8'h11);
        exp_ack(c + 5,  3'b010, 8'h11);
        exp_bus(c + 7,  1'b1, 1'b0, 16'h8002, 8'h22);
        exp_ack(c + 8,  3'b100, 8'h12);
        exp_bus(c + 10, 1'b1, 1'b0, 16'h8000, 8'h00);
        exp_ack(c + 11, 3'b001, 8'h10);
        serve(4, 3'b001);
        tick(2);
        chk("grant_after_rr", GRANT, 2'd0);

        // PAUSE raised during a core 2 write; core 0 waits until PAUSE drops.
        c = cyc;
        set_core(2, 1'b0, 1'b1, 16'h5A00, 8'h77);
        REQ = 3'b100;
        exp_bus(c + 1, 1'b0, 1'b1, 16'h5A00, 8'h77);
        exp_ack(c + 2, 3'b100, 8'h10);
        tick(1);
        PAUSE = 1'b1;
        set_core(0, 1'b0, 1'b1, 16'h0042, 8'h3E);
        REQ[0] = 1'b1;
        serve(1, 3'b000);
        tick(c + 10 - cyc);
        PAUSE = 1'b0;
        exp_bus(c + 11, 1'b0, 1'b1, 16'h0042, 8'h3E);
        exp_ack(c + 12, 3'b001, 8'h10);
        serve(1, 3'b000);
        tick(2);

        // Reset while a core 1 read sits in WAIT.
        c = cyc;
        set_core(1, 1'b1, 1'b0, 16'h9999, 8'h44);
        dev_push(-1, 8'h00);
        REQ = 3'b010;
        exp_bus(c + 1, 1'b1, 1'b0, 16'h9999, 8'h44);
        tick(3);
        RESET_N = 1'b0;
        REQ = 3'b000;
        tick(1);
        chk("midreset_ack_rdata", {ACK, RDATA}, 11'h000);
        chk("midreset_dev", {DEV_AD, DEV_RD, DEV_WR, DEV_DI}, 26'h0);
        chk("midreset_grant", GRANT, 2'd0);
        RESET_N = 1'b1;
        tick(1);
        c = cyc;
        set_core(0, 1'b0, 1'b1, 16'h1111, 8'h01);
        set_core(1, 1'b0, 1'b1, 16'h2222, 8'h02);
        REQ = 3'b011;
        exp_bus(c + 1, 1'b0, 1'b1, 16'h1111, 8'h01);
        exp_ack(c + 2, 3'b001, 8'h00);
        exp_bus(c + 4, 1'b0, 1'b1, 16'h2222, 8'h02);
        exp_ack(c + 5, 3'b010, 8'h00);
        serve(2, 3'b000);
        tick(2);

`ifdef DEVARB_TIMEOUT_EN
        // Read with no device answer times out after 4 WAIT cycles; flag is sticky.
        c = cyc;
        set_core(0, 1'b1, 1'b0, 16'h0ABC, 8'h00);
        dev_push(-1, 8'h00);
        REQ = 3'b001;
        exp_bus(c + 1, 1'b1, 1'b0, 16'h0ABC, 8'h00);
        exp_ack(c + 6, 3'b001, 8'hFF);
        serve(1, 3'b000);
        tick(1);
        chk("tmo_err_set", TMO_ERR, 1'b1);
        tick(1);
        c = cyc;
        set_core(0, 1'b1, 1'b0, 16'h0ABD, 8'h00);
        dev_push(0, 8'h55);
        REQ = 3'b001;
        exp_bus(c + 1, 1'b1, 1'b0, 16'h0ABD, 8'h00);
        exp_ack(c + 2, 3'b001, 8'h55);
        serve(1, 3'b000);
        tick(2);
        chk("tmo_err_sticky", TMO_ERR, 1'b1);
`else
        chk("tmo_err_tied", TMO_ERR, 1'b0);
`endif

        tick(3);
        chk("bus_q_drained", 64'(bus_q.size()), 64'(0));
        chk("ack_q_drained", 64'(ack_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
